// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: round-robin sharing of one block-RAM port among NUM_REQ requesters.
// Define DPRAM_ARB_PRIO_EN to give requester 0 strict priority over the round-robin group.
module dpram_port_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int DATA_WIDTH    = 128,
   parameter int ADDRESS_WIDTH = 10,
   parameter int RAM_LATENCY   = 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ-1:0]               req_we,
   input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
   output logic [NUM_REQ-1:0]               req_ready,
   output logic [NUM_REQ-1:0]               rsp_valid,
   output logic [DATA_WIDTH-1:0]            rsp_data,
   output logic                             ram_en,
   output logic                             ram_we,
   output logic [ADDRESS_WIDTH-1:0]         ram_addr,
   output logic [DATA_WIDTH-1:0]            ram_din,
   output logic                             ram_rst,
   input  logic [DATA_WIDTH-1:0]            ram_dout
);
   localparam int PW = $clog2(NUM_REQ);
`ifdef DPRAM_ARB_PRIO_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif
   logic [PW-1:0]      ptr, gidx, nxt;
   logic [PW:0]        idx;
   logic               gnt;
   logic [NUM_REQ-1:0] tag [RAM_LATENCY];
   // descending scan so the valid index closest to ptr is the one left standing
   always_comb begin
      gnt  = 1'b0;
      gidx = '0;
      idx  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         idx = {1'b0, ptr} + (PW+1)'(i);
         idx = idx >= (PW+1)'(NUM_REQ) ? idx - (PW+1)'(NUM_REQ) : idx;
         if (req_valid[idx[PW-1:0]] && !(PRIO && idx == '0)) begin
            gnt  = 1'b1;
            gidx = idx[PW-1:0];
         end
      end
      if (PRIO && req_valid[0]) begin
         gnt  = 1'b1;
         gidx = '0;
      end
      if (rst)
         gnt = 1'b0;
   end
   assign req_ready = gnt ? NUM_REQ'(1) << gidx : '0;
   assign ram_en    = gnt;
   assign ram_we    = gnt & req_we[gidx];
   assign ram_addr  = gnt ? req_addr[gidx*ADDRESS_WIDTH +: ADDRESS_WIDTH] : '0;
   assign ram_din   = gnt ? req_wdata[gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
   assign ram_rst   = rst;
   assign nxt       = gidx == PW'(NUM_REQ - 1) ? (PRIO ? PW'(1) : PW'(0)) : gidx + 1'b1;
   // with strict priority, grants to requester 0 leave the round-robin position alone
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= '0;
         for (int i = 0; i < RAM_LATENCY; i++)
            tag[i] <= '0;
      end else begin
         if (gnt && !(PRIO && gidx == '0))
            ptr <= nxt;
         tag[0] <= req_ready & ~req_we;
         for (int i = 1; i < RAM_LATENCY; i++)
            tag[i] <= tag[i-1];
      end
   end
   assign rsp_valid = tag[RAM_LATENCY-1];
   assign rsp_data  = ram_dout;
endmodule

// File: tb/tb_dpram_port_arbiter.sv
// tb_dpram_port_arbiter: drives dpram_port_arbiter against a behavioural no_change RAM,
// tracking expected grants and read responses with a reference arbiter and a response queue.
module tb_dpram_port_arbiter;
   localparam int N = 4, DW = 128, AW = 10, LAT = 2;
`ifdef DPRAM_ARB_PRIO_EN
   localparam bit PRIO = 1'b1;
`else
   localparam bit PRIO = 1'b0;
`endif
   logic          clk = 1'b0, rst = 1'b1;
   logic [N-1:0]  req_valid, req_we, req_ready, rsp_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [DW-1:0] rsp_data, ram_din, ram_dout;
   logic [AW-1:0] ram_addr;
   logic          ram_en, ram_we, ram_rst;
   logic [DW-1:0] mem [1024];
   logic [DW-1:0] shadow [1024];
   logic [DW-1:0] rd [LAT];
   typedef struct { int due; logic [N-1:0] tag; logic [DW-1:0] data; } exp_t;
   exp_t          sb [$];
   int            n_chk = 0, n_fail = 0, cyc = 0, mptr = 0, gi, a;
   logic [N-1:0]  eg = '0;

   always #5 clk = ~clk;

   dpram_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .RAM_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_rst(ram_rst), .ram_dout(ram_dout));

   // no_change RAM port: writes leave the output pipeline untouched
   always @(posedge clk or posedge ram_rst) begin
      if (ram_rst) begin
         for (int i = 0; i < LAT; i++) rd[i] <= '0;
      end else begin
         if (ram_en && ram_we) mem[ram_addr] <= ram_din;
         if (ram_en && !ram_we) rd[0] <= mem[ram_addr];
         for (int i = 1; i < LAT; i++) rd[i] <= rd[i-1];
      end
   end
   assign ram_dout = rd[LAT-1];

   task automatic chk(input string t, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", t, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] pat(input int adr);
      return {4{32'(adr) ^ 32'hC0DE_0000}};
   endfunction

   function automatic logic [N-1:0] mgrant(input logic [N-1:0] v, input int p);
      if (PRIO && v[0]) return N'(1);
      for (int i = 0; i < N; i++) begin
         int j = (p + i) % N;
         if (v[j] && !(PRIO && j == 0)) return N'(1) << j;
      end
      return '0;
   endfunction

   function automatic int mnext(input logic [N-1:0] g, input int p);
      for (int j = 0; j < N; j++)
         if (g[j]) return (PRIO && j == 0) ? p : ((j + 1) % N == 0 && PRIO) ? 1 : (j + 1) % N;
      return p;
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         eg = '0;
         mptr = 0;
         sb.delete();
         chk("rst_ready", DW'(req_ready), '0);
         chk("rst_ram_en", DW'(ram_en), '0);
         chk("rst_rsp_valid", DW'(rsp_valid), '0);
      end else begin
         if (sb.size() != 0 && sb[0].due == cyc) begin
            chk("rsp_tag", DW'(rsp_valid), DW'(sb[0].tag));
            chk("rsp_data", rsp_data, sb[0].data);
            void'(sb.pop_front());
         end else
            chk("rsp_idle", DW'(rsp_valid), '0);
         eg = mgrant(req_valid, mptr);
         chk("grant", DW'(req_ready), DW'(eg));
         chk("ram_en", DW'(ram_en), DW'(|eg));
         gi = -1;
         for (int j = 0; j < N; j++) if (eg[j]) gi = j;
         if (gi >= 0) begin
            a = int'(req_addr[gi*AW +: AW]);
            chk("ram_we", DW'(ram_we), DW'(req_we[gi]));
            chk("ram_addr", DW'(ram_addr), DW'(a));
            chk("ram_din", ram_din, req_wdata[gi*DW +: DW]);
            if (req_we[gi]) shadow[a] = req_wdata[gi*DW +: DW];
            else sb.push_back('{due: cyc + LAT, tag: eg, data: shadow[a]});
         end else begin
            chk("idle_we", DW'(ram_we), '0);
            chk("idle_addr", DW'(ram_addr), '0);
            chk("idle_din", ram_din, '0);
         end
      end
   end

   always @(posedge clk) begin
      if (!rst) mptr = mnext(eg, mptr);
      cyc++;
   end

   task automatic drv(input int i, input logic v, input logic we, input logic [AW-1:0] ad, input logic [DW-1:0] d);
      req_valid[i] = v;
      req_we[i] = we;
      req_addr[i*AW +: AW] = ad;
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic idle_all();
      req_valid = '0;
      req_we = '0;
   endtask

   task automatic step(input string t, input logic [N-1:0] exp);
      @(negedge clk);
      chk(t, DW'(req_ready), DW'(exp));
      chk({t, "_en"}, DW'(ram_en), DW'(|exp));
      @(posedge clk);
      #1;
   endtask

   task automatic rsp_at(input string t, input logic [N-1:0] ev, input logic [DW-1:0] ed);
      @(negedge clk);
      chk(t, DW'(rsp_valid), DW'(ev));
      if (ev != '0) chk({t, "_data"}, rsp_data, ed);
      @(posedge clk);
      #1;
   endtask

   initial begin
      req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < 1024; i++) begin
         shadow[i] = pat(i);
         mem[i] <= pat(i);
      end
      repeat (3) @(posedge clk);
      #1;
      drv(2, 1'b1, 1'b0, 10'h007, '0);
      step("rst_hold", '0);
      idle_all();
      rst = 1'b0;
      step("idle", '0);
      // lone requester: write then read back on consecutive cycles
      drv(2, 1'b1, 1'b1, 10'h005, 128'hA5A5);
      step("t2_wr", 4'b0100);
      drv(2, 1'b1, 1'b0, 10'h005, '0);
      step("t2_rd", 4'b0100);
      idle_all();
      rsp_at("t2_gap", '0, '0);
      rsp_at("t2_rsp", 4'b0100, 128'hA5A5);
      // reset while a read is in flight; pointer was left at 2
      drv(1, 1'b1, 1'b0, 10'h040, '0);
      step("t1_rd", 4'b0010);
      idle_all();
      rst = 1'b1;
      drv(1, 1'b1, 1'b0, 10'h041, '0);
      drv(3, 1'b1, 1'b0, 10'h043, '0);
      step("t1_rst_a", '0);
      step("t1_rst_b", '0);
      rst = 1'b0;
      step("t1_first", 4'b0010);
      step("t1_next", 4'b1000);
      idle_all();
      repeat (LAT + 1) step("t1_drain", '0);
`ifndef DPRAM_ARB_PRIO_EN
      rst = 1'b1;
      step("t3_rst", '0);
      rst = 1'b0;
      for (int i = 0; i < N; i++) drv(i, 1'b1, 1'b0, AW'(10'h100 + i), '0);
      for (int k = 0; k < 8; k++) step($sformatf("t3_g%0d", k), N'(1) << (k % N));
      idle_all();
      repeat (LAT + 1) step("t3_drain", '0);
`endif
      // requester 1 withdraws its write before ever being granted
      drv(0, 1'b1, 1'b0, 10'h200, '0);
      drv(1, 1'b1, 1'b1, 10'h2FF, 128'hDEAD);
      step("t4_both", 4'b0001);
      drv(1, 1'b0, 1'b0, 10'h2FF, '0);
      repeat (4) step("t4_hog", 4'b0001);
      idle_all();
      repeat (LAT) step("t4_idle", '0);
      drv(1, 1'b1, 1'b0, 10'h2FF, '0);
      step("t4_chk_rd", 4'b0010);
      idle_all();
      rsp_at("t4_gap", '0, '0);
      rsp_at("t4_nowrite", 4'b0010, pat(10'h2FF));
      // write by 0, read of the same address by 3 on the next cycle
      drv(0, 1'b1, 1'b1, 10'h033, 128'h1234_5678_9ABC);
      step("t5_wr", 4'b0001);
      idle_all();
      drv(3, 1'b1, 1'b0, 10'h033, '0);
      step("t5_rd", 4'b1000);
      idle_all();
      rsp_at("t5_no_wr_rsp", '0, '0);
      rsp_at("t5_rsp", 4'b1000, 128'h1234_5678_9ABC);
`ifdef DPRAM_ARB_PRIO_EN
      rst = 1'b1;
      step("t6_rst", '0);
      rst = 1'b0;
      for (int i = 0; i < N; i++) drv(i, 1'b1, 1'b0, AW'(10'h180 + i), '0);
      repeat (4) step("t6_prio", 4'b0001);
      drv(0, 1'b0, 1'b0, 10'h180, '0);
      step("t6_g1", 4'b0010);
      step("t6_g2", 4'b0100);
      step("t6_g3", 4'b1000);
      step("t6_g1b", 4'b0010);
      idle_all();
`endif
      repeat (LAT + 2) step("final_drain", '0);
      chk("sb_empty", DW'(sb.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
